mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the core's single cache-line memory port between N miss/store requesters: instruction-fetch fill, data-cache fill and data-cache store.
- Sits between the cache tag/data stages and the memory interface.
- Round-robin arbitration with one transaction outstanding at a time.
- Request held until granted; response routed back to the winner only.

Parameters:
NUM_REQUESTERS, 2, number of requesters (2..8)
ADDR_WIDTH, 32, byte address width
LINE_BITS, 512, cache line width; mask width LINE_BITS/8

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQUESTERS  per-requester request pending
req_addr  input  NUM_REQUESTERS*ADDR_WIDTH  line address, slice i = requester i
req_write_en  input  NUM_REQUESTERS  1 = store, 0 = fill read
req_write_data  input  NUM_REQUESTERS*LINE_BITS  store data
req_write_mask  input  NUM_REQUESTERS*(LINE_BITS/8)  store byte enables
req_grant  output  NUM_REQUESTERS  one-cycle pulse: request captured
resp_valid  output  NUM_REQUESTERS  one-cycle pulse: transaction complete
resp_data  output  LINE_BITS  fill data, shared, valid with resp_valid
mem_request_valid  output  1  request to memory
mem_request_addr  output  ADDR_WIDTH  captured address
mem_write_en  output  1  captured write flag
mem_write_data  output  LINE_BITS  captured store data
mem_write_mask  output  LINE_BITS/8  captured byte enables
mem_request_ready  input  1  memory accepts request this cycle
mem_response_valid  input  1  memory completion (read data or write ack)
mem_response_data  input  LINE_BITS  read data
arb_busy  output  1  state != IDLE

Behaviour:
- Reset: state IDLE; rr_ptr=0; all outputs 0; any in-flight transaction discarded, no resp_valid issued.
- States IDLE, ISSUE, WAIT_RESP.
- IDLE: if any req_valid, pick first set bit searching from rr_ptr upward, wrapping at NUM_REQUESTERS-1 to 0.
  - On that edge: capture addr/write_en/data/mask and winner index; rr_ptr <= winner+1 (mod N); go to ISSUE.
  - req_grant[winner] pulses in the first ISSUE cycle (registered, 1-cycle latency).
- Requester protocol: hold request stable until req_grant; may present the next request from the cycle after grant. Deasserting before grant is legal; arbitration re-evaluates every IDLE cycle.
- ISSUE: mem_request_valid=1 with captured fields.
  - mem_request_ready=1: go to WAIT_RESP.
  - Same cycle also mem_response_valid=1: complete directly as below, go to IDLE.
- WAIT_RESP: mem_request_valid=0. On mem_response_valid: register mem_response_data into resp_data, pulse resp_valid[winner] next cycle, go to IDLE.
- Write completion also pulses resp_valid. resp_data for writes is don't-care but must equal the registered memory data.
- mem_response_valid in IDLE is ignored; no output changes.
- Back-to-back throughput: at most one transaction per 3 cycles (IDLE, ISSUE, WAIT_RESP minimum, or 2 with same-cycle ready+response).
- resp_data holds its value until the next completion.
- Fairness: a continuously requesting requester is granted within NUM_REQUESTERS transactions.
- reset during ISSUE or WAIT_RESP: next cycle IDLE, mem_request_valid=0, no grant or response pulse.

Optional Feature:
ARB_PERF_COUNTERS_EN
- Defined: adds outputs perf_grant_count (NUM_REQUESTERS*32, per-requester grants) and perf_wait_cycles (32, cycles with any req_valid not granted that cycle, excluding the capture edge). Counters clear on reset and wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Single read: N=2, req_valid=01, addr=0x1000, ready on 1st ISSUE cycle, response 2 cycles later with data 0xA5...: grant[0] cycle 1, mem_request_addr=0x1000, resp_valid=01 with resp_data=0xA5...; arb_busy returns 0.
- Round-robin: N=3, req_valid=111 held, each regranted after grant: grant order 0,1,2,0,1,2; no requester starved.
- Store: req_write_en=1, mask=all-ones, data=pattern: mem_write_en=1, mem_write_data/mask match; write ack yields resp_valid pulse.
- Backpressure: mem_request_ready low 5 cycles: mem_request_valid and fields stable for all 5 cycles; a new req_valid on the other port is not granted until completion.
- Same-cycle ready+response in ISSUE: resp_valid next cycle, state IDLE, no WAIT_RESP cycle; spurious mem_response_valid in IDLE produces no resp_valid.
- Reset in WAIT_RESP: assert reset 1 cycle, then memory response arrives: no resp_valid, rr_ptr=0, requester 0 wins next if both request.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory bus bundle for the cache-line memory port arbiter
//
// Groups every handshake/bus signal of mem_port_arbiter.
//   slave  : the arbiter side (drives req_grant, resp_*, mem_request_*, mem_write_*, arb_busy)
//   master : the environment side (requesters and memory; drives req_*, mem_request_ready, mem_response_*)
// Slice i of each packed req_* vector belongs to requester i.
interface mem_port_arbiter_if #(
    parameter int NUM_REQUESTERS = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_BITS      = 512
);
    localparam int MASK_BITS = LINE_BITS / 8;

    logic [NUM_REQUESTERS-1:0]            req_valid;
    logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQUESTERS-1:0]            req_write_en;
    logic [NUM_REQUESTERS*LINE_BITS-1:0]  req_write_data;
    logic [NUM_REQUESTERS*MASK_BITS-1:0]  req_write_mask;
    logic [NUM_REQUESTERS-1:0]            req_grant;
    logic [NUM_REQUESTERS-1:0]            resp_valid;
    logic [LINE_BITS-1:0]                 resp_data;
    logic                                 mem_request_valid;
    logic [ADDR_WIDTH-1:0]                mem_request_addr;
    logic                                 mem_write_en;
    logic [LINE_BITS-1:0]                 mem_write_data;
    logic [MASK_BITS-1:0]                 mem_write_mask;
    logic                                 mem_request_ready;
    logic                                 mem_response_valid;
    logic [LINE_BITS-1:0]                 mem_response_data;
    logic                                 arb_busy;

    modport slave (
        input  req_valid, req_addr, req_write_en, req_write_data, req_write_mask,
        input  mem_request_ready, mem_response_valid, mem_response_data,
        output req_grant, resp_valid, resp_data,
        output mem_request_valid, mem_request_addr, mem_write_en, mem_write_data, mem_write_mask,
        output arb_busy
    );

    modport master (
        output req_valid, req_addr, req_write_en, req_write_data, req_write_mask,
        output mem_request_ready, mem_response_valid, mem_response_data,
        input  req_grant, resp_valid, resp_data,
        input  mem_request_valid, mem_request_addr, mem_write_en, mem_write_data, mem_write_mask,
        input  arb_busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one cache-line memory port, one transaction in flight
//
// Ports:
//   clk    : core clock
//   reset  : synchronous, active-high reset (drops any in-flight transaction silently)
//   bus    : mem_port_arbiter_if.slave - requester request/grant/response and memory request/response
//   perf_grant_count : per-requester grant counters, 32 bits each   (only with ARB_PERF_COUNTERS_EN)
//   perf_wait_cycles : cycles with a pending request and no capture (only with ARB_PERF_COUNTERS_EN)
// Optional feature macro: ARB_PERF_COUNTERS_EN
module mem_port_arbiter #(
    parameter int NUM_REQUESTERS = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_BITS      = 512
) (
    input  logic                         clk,
    input  logic                         reset,
    mem_port_arbiter_if.slave            bus
`ifdef ARB_PERF_COUNTERS_EN
    ,
    output logic [NUM_REQUESTERS*32-1:0] perf_grant_count,
    output logic [31:0]                  perf_wait_cycles
`endif
);
    localparam int MASK_BITS = LINE_BITS / 8;
    localparam int IDX_W     = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [IDX_W-1:0]          r_rr_ptr;
    logic [IDX_W-1:0]          r_winner;
    logic [IDX_W-1:0]          w_winner;
    logic                      w_any;
    logic                      w_capture;
    logic                      w_complete;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic                      r_write_en;
    logic [LINE_BITS-1:0]      r_write_data;
    logic [MASK_BITS-1:0]      r_write_mask;
    logic [NUM_REQUESTERS-1:0] r_grant;
    logic [NUM_REQUESTERS-1:0] r_resp_valid;
    logic [LINE_BITS-1:0]      r_resp_data;

    // Round-robin pick: the lowest requester at or above r_rr_ptr wins; if none is
    // pending there, fall back to the lowest pending requester overall (the wrap).
    always_comb begin
        w_any    = |bus.req_valid;
        w_winner = '0;
        for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) w_winner = IDX_W'(i);
        end
        for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (IDX_W'(i) >= r_rr_ptr)) w_winner = IDX_W'(i);
        end
    end

    assign w_capture  = (r_state == IDLE) && w_any;
    // A response arriving in the same ISSUE cycle the request is accepted finishes
    // the transaction without a WAIT_RESP cycle.
    assign w_complete = ((r_state == ISSUE) && bus.mem_request_ready && bus.mem_response_valid) ||
                        ((r_state == WAIT_RESP) && bus.mem_response_valid);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (w_any) w_next_state = ISSUE;
            ISSUE:     if (bus.mem_request_ready)
                           w_next_state = bus.mem_response_valid ? IDLE : WAIT_RESP;
            WAIT_RESP: if (bus.mem_response_valid) w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_request_valid = (r_state == ISSUE);
        bus.arb_busy          = (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_winner     <= '0;
            r_addr       <= '0;
            r_write_en   <= 1'b0;
            r_write_data <= '0;
            r_write_mask <= '0;
            r_grant      <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else begin
            r_grant      <= '0;
            r_resp_valid <= '0;
            if (w_capture) begin
                r_winner     <= w_winner;
                r_addr       <= bus.req_addr[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
                r_write_en   <= bus.req_write_en[w_winner];
                r_write_data <= bus.req_write_data[w_winner*LINE_BITS +: LINE_BITS];
                r_write_mask <= bus.req_write_mask[w_winner*MASK_BITS +: MASK_BITS];
                r_rr_ptr     <= (w_winner == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : w_winner + 1'b1;
                r_grant      <= NUM_REQUESTERS'(1) << w_winner;
            end
            if (w_complete) begin
                r_resp_data  <= bus.mem_response_data;
                r_resp_valid <= NUM_REQUESTERS'(1) << r_winner;
            end
        end
    end

    assign bus.req_grant        = r_grant;
    assign bus.resp_valid       = r_resp_valid;
    assign bus.resp_data        = r_resp_data;
    assign bus.mem_request_addr = r_addr;
    assign bus.mem_write_en     = r_write_en;
    assign bus.mem_write_data   = r_write_data;
    assign bus.mem_write_mask   = r_write_mask;

`ifdef ARB_PERF_COUNTERS_EN
    logic [NUM_REQUESTERS*32-1:0] r_perf_grant_count;
    logic [31:0]                  r_perf_wait_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_grant_count <= '0;
            r_perf_wait_cycles <= '0;
        end else begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                if (w_capture && (w_winner == IDX_W'(i)))
                    r_perf_grant_count[i*32 +: 32] <= r_perf_grant_count[i*32 +: 32] + 32'd1;
            end
            if (w_any && !w_capture) r_perf_wait_cycles <= r_perf_wait_cycles + 32'd1;
        end
    end

    assign perf_grant_count = r_perf_grant_count;
    assign perf_wait_cycles = r_perf_wait_cycles;
`endif
endmodule
